ccff_bitstream_loader: RTL and testbench
========================================

// Module: ccff_bitstream_loader
// PURPOSE
//  Configuration-chain driver sitting directly upstream of the I/O grid tiles' ccff_head input.
//  Accepts bitstream words over a valid/ready stream, serialises them MSB-first onto ccff_head,
//  and pulses a shift enable that gates the chain's prog_clk, so stalls never inject garbage bits.
//  Captures the bits falling out of ccff_tail and repacks them into readback words, for
//  chain-integrity checks and verification of the previous configuration.
// PARAMETERS
//  CHAIN_LEN  128  total configuration flip-flops in the chain (>=1)
//  WORD_W     8    bitstream/readback word width (>=2)
//  CNT_W      16   bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  prog_clk       in   1        programming clock; all state updates on rising edge
//  prog_reset     in   1        asynchronous, active-high reset
//  start          in   1        begin a load; sampled in IDLE or DONE only
//  abort          in   1        cancel an in-progress load
//  s_data         in   WORD_W   bitstream word; bit WORD_W-1 is shifted first
//  s_valid        in   1        s_data valid
//  s_ready        out  1        loader accepts s_data this cycle
//  ccff_head      out  1        serial config bit to chain head
//  ccff_shift_en  out  1        chain clock enable; chain samples ccff_head on each edge where it is 1
//  ccff_tail      in   1        serial bit from chain tail (old contents)
//  rb_data        out  WORD_W   readback word
//  rb_valid       out  1        one-cycle pulse, rb_data valid; no backpressure
//  busy           out  1        high in FETCH/SHIFT
//  done           out  1        high in DONE (all CHAIN_LEN bits shifted)
//  bit_count      out  CNT_W    bits shifted so far in current load
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including s_ready, ccff_head, ccff_shift_en, rb_data and bit_count.
//  States: IDLE, FETCH, SHIFT, DONE.
//   IDLE/DONE --start--> FETCH: clear bit_count, rb shift reg and done. start is ignored in FETCH/SHIFT.
//   FETCH: s_ready=1. On s_valid&s_ready: word -> sr, word bit cnt=0, go SHIFT.
//   SHIFT: ccff_shift_en=1 and ccff_head=sr[WORD_W-1].
//     Each cycle: sr<<=1; bit_count++; rb_sr={rb_sr,ccff_tail}.
//     After the last bit of the word: go FETCH if bit_count<CHAIN_LEN, else go DONE.
//  Outputs: s_ready, ccff_head and ccff_shift_en are decoded from registered state only.
//   No combinational path from any input.
//  Throughput: WORD_W bits per WORD_W+1 cycles, with one FETCH bubble per word. The bubble has shift_en=0.
//  Input stall: FETCH holds with shift_en=0. The chain does not move.
//  Final partial word (CHAIN_LEN % WORD_W != 0):
//   Only the top remaining bits of the last word are shifted; its low bits are discarded.
//  Chain order: i-th bit shifted (0-based) ends in chain FF CHAIN_LEN-1-i, where FF 0 is nearest the head.
//  Readback:
//   - rb_valid pulses the cycle after each WORD_W-th captured bit, and after the final bit.
//   - The first captured bit is the MSB of the word.
//   - A final partial word is left-aligned, with zeros in the unused low bits.
//  DONE: done=1 and busy=0. Held until start (new load) or reset.
//  abort in FETCH/SHIFT: IDLE next cycle; shift_en=0 from that cycle; done stays 0.
//   No rb_valid for the partial word. abort has priority over s_valid and the end-of-word transition.
//   abort in IDLE/DONE is ignored.
//  Simultaneous start+abort in IDLE/DONE: start wins.
//  Reset mid-load: immediate return to IDLE with all outputs 0; chain contents are undefined to software.
//  bit_count saturates at CHAIN_LEN and never wraps.
// TESTING
//  Chain model: CHAIN_LEN FFs clocked by prog_clk & ccff_shift_en.
//  1. CHAIN_LEN=8, WORD_W=8; chain preloaded so tail emits 0x5A; start, send 0xA5
//     -> 8 cycles with shift_en=1; FF7..FF0 = 1,0,1,0,0,1,0,1; rb_data=0x5A with one rb_valid; done=1, bit_count=8.
//  2. CHAIN_LEN=12, WORD_W=8; send 0xF0 then 0x3C
//     -> 12 shifts total, only 0x3 shifted from the second word; rb_valid twice, the second word left-aligned (low 4 bits 0).
//  3. s_valid held low 5 cycles between words
//     -> s_ready=1 and shift_en=0 throughout; chain model unchanged; final contents same as no-stall case.
//  4. abort after 3 bits of a 16-bit load -> IDLE next cycle; shift_en=0; done=0; no further rb_valid.
//     start pulse at the 2nd SHIFT cycle -> ignored, bit_count unaffected.
//  5. prog_reset asserted asynchronously mid-SHIFT -> all outputs 0 before the next edge.
//     Then start, and a full 0xA5 load after release -> correct contents, done=1.
//  6. Back-to-back loads: start in DONE with new data -> done drops, bit_count restarts at 0.
//     Readback equals the first load's data.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Drives the head of a configuration flip-flop chain from a valid/ready stream
//   of bitstream words. Each word is shifted out MSB-first on ccff_head. The chain
//   advances only on cycles where ccff_shift_en is 1, so input stalls never move it.
//   The old chain contents that fall out of ccff_tail are repacked into readback
//   words, so the previous configuration can be checked.
//
// Ports
//   prog_clk       clock; all state updates on the rising edge
//   prog_reset     asynchronous, active-high reset
//   start          begin a load (honoured in IDLE/DONE only)
//   abort          cancel an in-progress load (honoured in FETCH/SHIFT only)
//   s_data/s_valid/s_ready  bitstream word stream; s_data[WORD_W-1] goes out first
//   ccff_head      serial configuration bit to the chain head
//   ccff_shift_en  chain clock enable
//   ccff_tail      serial bit from the chain tail
//   rb_data/rb_valid  readback word and its one-cycle strobe
//   busy           high while fetching or shifting
//   done           high once all CHAIN_LEN bits have been shifted
//   bit_count      bits shifted so far in the current load

module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 128,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int WC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  LAST_BIT = WC_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] sr_reg;         // word being serialised, MSB is the next bit out
  logic [WC_W-1:0]   word_bit_reg;   // position inside the current word
  logic [CNT_W-1:0]  bit_count_reg;
  logic [WORD_W-1:0] rb_sr_reg;      // readback bits captured from the tail
  logic [WORD_W-1:0] rb_data_reg;
  logic              rb_valid_reg;

  // Readback and input words share the same alignment (both start at bit 0 of
  // the load and advance one bit per shift), so one position counter serves both.
  logic [WORD_W-1:0] rb_next;
  logic [WORD_W-1:0] rb_aligned;
  logic              last_chain_bit;
  logic              last_word_bit;

  assign rb_next        = {rb_sr_reg[WORD_W-2:0], ccff_tail};
  // A short final word is left-aligned: move the captured bits to the top.
  assign rb_aligned     = rb_next << (LAST_BIT - word_bit_reg);
  assign last_chain_bit = (bit_count_reg >= (LEN - CNT_W'(1)));
  assign last_word_bit  = (word_bit_reg == LAST_BIT);

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_reg     <= ST_IDLE;
      sr_reg        <= '0;
      word_bit_reg  <= '0;
      bit_count_reg <= '0;
      rb_sr_reg     <= '0;
      rb_data_reg   <= '0;
      rb_valid_reg  <= 1'b0;
    end else begin
      rb_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // start wins over a simultaneous abort because abort is not looked at here
          if (start) begin
            state_reg     <= ST_FETCH;
            bit_count_reg <= '0;
            rb_sr_reg     <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (s_valid) begin
            sr_reg       <= s_data;
            word_bit_reg <= '0;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // ccff_shift_en is high for this whole cycle, so the chain moves on this
          // edge even if abort is raised; the bookkeeping follows the chain.
          sr_reg       <= {sr_reg[WORD_W-2:0], 1'b0};
          rb_sr_reg    <= rb_next;
          word_bit_reg <= word_bit_reg + WC_W'(1);
          if (bit_count_reg != LEN) begin
            bit_count_reg <= bit_count_reg + CNT_W'(1);
          end
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (last_chain_bit) begin
            state_reg    <= ST_DONE;
            rb_data_reg  <= rb_aligned;
            rb_valid_reg <= 1'b1;
          end else if (last_word_bit) begin
            state_reg    <= ST_FETCH;
            rb_data_reg  <= rb_next;
            rb_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decodes of registered state only.
  assign s_ready       = (state_reg == ST_FETCH);
  assign ccff_shift_en = (state_reg == ST_SHIFT);
  assign ccff_head     = (state_reg == ST_SHIFT) & sr_reg[WORD_W-1];
  assign busy          = (state_reg == ST_FETCH) | (state_reg == ST_SHIFT);
  assign done          = (state_reg == ST_DONE);
  assign bit_count     = bit_count_reg;
  assign rb_data       = rb_data_reg;
  assign rb_valid      = rb_valid_reg;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader with a 12-FF chain and 8-bit words, so every
// load has one full word and one partial final word.
module tb_ccff_bitstream_loader;

  localparam int L  = 12;
  localparam int W  = 8;
  localparam int CW = 16;
  localparam int NW = (L + W - 1) / W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          head;
  logic          shift_en;
  logic          tail;
  logic [W-1:0]  rb_data;
  logic          rb_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;

  ccff_bitstream_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(CW)) dut (
    .prog_clk(clk), .prog_reset(rst), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(head), .ccff_shift_en(shift_en), .ccff_tail(tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Physical chain: FF 0 nearest the head, tail is FF L-1.
  logic [L-1:0] chain;
  logic         preload_en = 1'b0;
  logic [L-1:0] preload_val = '0;
  assign tail = chain[L-1];
  always @(posedge clk) begin
    if (preload_en) chain <= preload_val;
    else if (shift_en) chain <= {chain[L-2:0], head};
  end

  // Monitor: running totals sampled away from the active edge.
  int           shift_total = 0;
  int           busy_total = 0;
  int           overlap = 0;
  logic [W-1:0] rb_q[$];
  always @(negedge clk) begin
    if (shift_en) shift_total++;
    if (busy) busy_total++;
    if (shift_en && s_ready) overlap++;
    if (rb_valid) rb_q.push_back(rb_data);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 0);
    check_eq({tag, "_head"}, head, 0);
    check_eq({tag, "_shift_en"}, shift_en, 0);
    check_eq({tag, "_rb_data"}, rb_data, 0);
    check_eq({tag, "_rb_valid"}, rb_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_bit_count"}, bit_count, 0);
  endtask

  // Wait (bounded) for FETCH, hold s_valid low for 'stall' FETCH cycles, then hand the word over.
  task automatic send_word(input logic [W-1:0] w, input int stall);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("ready_wait", ok, 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_ready", s_ready, 1);
      check_eq("stall_shift_en", shift_en, 0);
    end
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = W'($urandom);
  endtask

  logic [W-1:0] last_w0, last_w1;

  task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input int st0, input int st1, input logic with_abort);
    logic [L-1:0] old_chain, exp_chain;
    logic [W-1:0] wd[NW];
    logic [W-1:0] exp_rb[NW];
    logic [W-1:0] r;
    logic [31:0]  got;
    int sh0, bz0, rb0, idx;
    logic ok;
    wd[0] = w0;
    wd[1] = w1;
    old_chain = chain;
    sh0 = shift_total;
    bz0 = busy_total;
    rb0 = rb_q.size();
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_bit_count", bit_count, 0);
    send_word(w0, st0);
    send_word(w1, st1);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("done_wait", ok, 1);
    @(negedge clk);
    // Reference: i-th bit sent lands in FF L-1-i; readback is old FF L-1 downward, left-aligned.
    for (int i = 0; i < L; i++) exp_chain[L-1-i] = wd[i / W][W-1-(i % W)];
    for (int j = 0; j < NW; j++) begin
      r = '0;
      for (int k = 0; k < W; k++) begin
        idx = j * W + k;
        if (idx < L) r[W-1-k] = old_chain[L-1-idx];
      end
      exp_rb[j] = r;
    end
    check_eq("chain", chain, exp_chain);
    check_eq("shift_cycles", shift_total - sh0, L);
    check_eq("busy_cycles", busy_total - bz0, NW + L + st0 + st1);
    check_eq("rb_count", rb_q.size() - rb0, NW);
    for (int j = 0; j < NW; j++) begin
      got = (rb0 + j < rb_q.size()) ? 32'(rb_q[rb0 + j]) : 32'hDEAD;
      check_eq("rb_word", got, exp_rb[j]);
    end
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_bit_count", bit_count, L);
    check_eq("end_shift_en", shift_en, 0);
    $display("load w=%h,%h stall=%0d,%0d start+abort=%0b rb=%h,%h chain=%h",
             w0, w1, st0, st1, with_abort, exp_rb[0], exp_rb[1], chain);
    last_w0 = w0;
    last_w1 = w1;
  endtask

  initial begin
    logic [L-1:0] old_chain;
    logic [W-1:0] w, a0, a1, mask;
    int rb0, sz;
    mask = '1;
    mask = mask << (NW * W - L);

    // Reset state with the chain preloaded so the tail emits 0x5A first.
    preload_val = {8'h5A, 4'(($urandom))};
    preload_en  = 1'b1;
    repeat (2) @(negedge clk);
    preload_en = 1'b0;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Basic load: 0xA5 then a partial word; readback starts with 0x5A.
    rb0 = rb_q.size();
    run_load(8'hA5, W'($urandom), 0, 0, 1'b0);
    check_eq("rb_first_5a", (rb_q.size() > rb0) ? 32'(rb_q[rb0]) : 32'hDEAD, 8'h5A);

    // Partial final word: only 0x3 of 0x3C goes into the chain.
    run_load(8'hF0, 8'h3C, 0, 0, 1'b0);
    check_eq("chain_f0_3", chain, 12'hF03);

    // Stalls between words, including a five-cycle stall.
    run_load(W'($urandom), W'($urandom), 5, 5, 1'b0);
    run_load(W'($urandom), W'($urandom), 0, 5, 1'b0);

    // Randomised loads.
    for (int n = 0; n < 6; n++)
      run_load(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Abort after three shifted bits; start during SHIFT is ignored.
    old_chain = chain;
    rb0 = rb_q.size();
    w = W'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(w, 0);
    check_eq("abort_shift1", shift_en, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_shift_en", shift_en, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_s_ready", s_ready, 0);
    check_eq("abort_bit_count", bit_count, 3);
    repeat (W + 2) @(negedge clk);
    check_eq("abort_chain", chain, {old_chain[L-4:0], w[W-1], w[W-2], w[W-3]});
    check_eq("abort_no_rb", rb_q.size() - rb0, 0);
    check_eq("abort_idle_shift_en", shift_en, 0);
    $display("abort w=%h chain=%h", w, chain);

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(W'($urandom), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    $display("async reset mid-shift");
    run_load(8'hA5, W'($urandom), 0, 0, 1'b0);

    // Back-to-back loads; start+abort in DONE: start wins.
    a0 = W'($urandom);
    a1 = W'($urandom);
    run_load(a0, a1, 0, 0, 1'b0);
    run_load(W'($urandom), W'($urandom), 1, 0, 1'b1);
    sz = rb_q.size();
    check_eq("b2b_rb0", (sz >= 2) ? 32'(rb_q[sz-2]) : 32'hDEAD, a0);
    check_eq("b2b_rb1", (sz >= 2) ? 32'(rb_q[sz-1]) : 32'hDEAD, a1 & mask);

    check_eq("shift_en_in_fetch", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
